// File: rtl/sorter_pkg.sv
// Shared types and schedule helpers for the iterative bitonic sorter.
// FSM encoding, step count and per-step (k, j) lookup.
package sorter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SORT,
    DONE
  } state_t;

  // k = 1 << kp, j = 1 << jq
  typedef struct packed {
    logic [2:0] kp;
    logic [2:0] jq;
  } kj_t;

  function automatic int steps_of(input int n);
    int lg;
    lg = $clog2(n);
    return lg * (lg + 1) / 2;
  endfunction

  function automatic kj_t kj_of(input int n,
                                input int step);
    kj_t r;
    int  cnt;
    int  lg;
    r   = '0;
    cnt = 0;
    lg  = $clog2(n);
    for (int p = 1; p <= 4; p++) begin
      for (int q = 3; q >= 0; q--) begin
        if (p <= lg && q < p) begin
          if (cnt == step) begin
            r.kp = 3'(p);
            r.jq = 3'(q);
          end
          cnt++;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bitonic_sort_sequencer_cmp.sv
// Unsigned two-input comparator: routes the smaller value to min.
// Ties keep a on min and b on max.
module bitonic_sort_sequencer_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] min,
  output logic [WIDTH-1:0] max
);

  logic lt;

  assign lt  = b < a;
  assign min = lt ? b : a;
  assign max = lt ? a : b;

endmodule

// File: rtl/bitonic_sort_sequencer.sv
// Iterative bitonic sorter: one compare-exchange layer per clock.
// Define SORTER_DESC_EN to produce descending order.
module bitonic_sort_sequencer
  import sorter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int N     = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*WIDTH-1:0] din,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*WIDTH-1:0] dout,
  output logic           busy
);

  localparam int S  = steps_of(N);
  localparam int SW = (S > 1) ? $clog2(S) : 1;
  localparam int IW = $clog2(N);
  localparam int P  = N / 2;

  state_t           state;
  logic [SW-1:0]    step;
  logic [WIDTH-1:0] bank [N];
  logic [WIDTH-1:0] nxt  [N];

  logic [WIDTH-1:0] ca   [P];
  logic [WIDTH-1:0] cb   [P];
  logic [WIDTH-1:0] cmin [P];
  logic [WIDTH-1:0] cmax [P];
  logic [IW-1:0]    pi   [P];
  logic [IW-1:0]    pl   [P];
  logic             pasc [P];

  kj_t kj;

  // Pair selection and direction for the current step
  always_comb begin
    kj = kj_of(N, int'(step));
    for (int p = 0; p < P; p++) begin
      int i;
      int l;
      int jq;
      int kp;
      jq = int'(kj.jq);
      kp = int'(kj.kp);
      i  = ((p >> jq) << (jq + 1)) | (p & ((1 << jq) - 1));
      l  = i | (1 << jq);
      pi[p] = IW'(i);
      pl[p] = IW'(l);
`ifdef SORTER_DESC_EN
      pasc[p] = ((i >> kp) & 1) != 0;
`else
      pasc[p] = ((i >> kp) & 1) == 0;
`endif
      ca[p] = bank[IW'(i)];
      cb[p] = bank[IW'(l)];
    end
  end

  genvar g;
  generate
    for (g = 0; g < P; g++) begin : g_cmp
      bitonic_sort_sequencer_cmp #(
        .WIDTH(WIDTH)
      ) u_cmp (
        .a  (ca[g]),
        .b  (cb[g]),
        .min(cmin[g]),
        .max(cmax[g])
      );
    end
    for (g = 0; g < N; g++) begin : g_out
      assign dout[g*WIDTH +: WIDTH] = bank[g];
    end
  endgenerate

  // Next bank contents after applying the current step
  always_comb begin
    for (int e = 0; e < N; e++) nxt[e] = bank[e];
    for (int p = 0; p < P; p++) begin
      nxt[pi[p]] = pasc[p] ? cmin[p] : cmax[p];
      nxt[pl[p]] = pasc[p] ? cmax[p] : cmin[p];
    end
  end

  // Control FSM, register bank and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      step      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      for (int e = 0; e < N; e++) bank[e] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            for (int e = 0; e < N; e++)
              bank[e] <= din[e*WIDTH +: WIDTH];
            step     <= '0;
            state    <= SORT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SORT: begin
          for (int e = 0; e < N; e++) bank[e] <= nxt[e];
          if (step == SW'(S - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            step <= step + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitonic_sort_sequencer.sv
// Self-checking bench for bitonic_sort_sequencer (WIDTH=4, N=4).
// Random and directed vectors against a plain array-sort model.
module tb_bitonic_sort_sequencer;

  localparam int W  = 4;
  localparam int NN = 4;
  localparam int LG = $clog2(NN);
  localparam int S  = LG * (LG + 1) / 2;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [NN*W-1:0] din;
  logic          out_valid;
  logic          out_ready;
  logic [NN*W-1:0] dout;
  logic          busy;

  int ncmp;
  int nerr;

  bitonic_sort_sequencer #(
    .WIDTH(W),
    .N    (NN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din      (din),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout     (dout),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  function automatic logic [NN*W-1:0] model(
      input logic [NN*W-1:0] v);
    int a [NN];
    int t;
    logic [NN*W-1:0] r;
    for (int e = 0; e < NN; e++)
      a[e] = int'(v[e*W +: W]);
    for (int x = 0; x < NN; x++)
      for (int y = 0; y < NN - 1 - x; y++)
`ifdef SORTER_DESC_EN
        if (a[y] < a[y+1]) begin
`else
        if (a[y] > a[y+1]) begin
`endif
          t = a[y];
          a[y] = a[y+1];
          a[y+1] = t;
        end
    r = '0;
    for (int e = 0; e < NN; e++)
      r[e*W +: W] = W'(a[e]);
    return r;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_dout"}, 64'(dout), 64'd0);
  endtask

  task automatic sort_one(input logic [NN*W-1:0] v,
                          input int hold,
                          input bit poke,
                          output logic [NN*W-1:0] got);
    int lat;
    logic [NN*W-1:0] snap;
    @(negedge clk);
    chk("pre_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    din       = v;
    @(negedge clk);
    in_valid = 1'b0;
    chk("busy_sort", 64'(busy), 64'd1);
    chk("in_ready_sort", 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (poke && lat == 1) begin
        in_valid = 1'b1;
        din      = '1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", 64'(lat), 64'(S));
    chk("dout", 64'(dout), 64'(model(v)));
    got  = dout;
    snap = dout;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_dout", 64'(dout), 64'(snap));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_valid", 64'(out_valid), 64'd0);
    chk("post_in_ready", 64'(in_ready), 64'd1);
    chk("post_busy", 64'(busy), 64'd0);
    if (poke) begin
      repeat (S + 2) @(negedge clk);
      chk("no_second", 64'(out_valid), 64'd0);
    end
  endtask

  initial begin
    logic [NN*W-1:0] got;
    logic [NN*W-1:0] v;
    ncmp      = 0;
    nerr      = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din       = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("idle");

    sort_one(16'h4729, 0, 1'b0, got);
`ifdef SORTER_DESC_EN
    chk("basic_const", 64'(got), 64'h2479);
`else
    chk("basic_const", 64'(got), 64'h9742);
`endif
    sort_one(16'h5555, 0, 1'b0, got);
    chk("dup5_const", 64'(got), 64'h5555);
    sort_one(16'h1313, 0, 1'b0, got);
`ifdef SORTER_DESC_EN
    chk("dup13_const", 64'(got), 64'h1133);
`else
    chk("dup13_const", 64'(got), 64'h3311);
`endif
    sort_one(16'h4729, 5, 1'b0, got);
    sort_one(16'h1842, 0, 1'b1, got);

    @(negedge clk);
    in_valid = 1'b1;
    din      = 16'hC5E1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    sort_one(16'h0F3A, 0, 1'b0, got);
`ifdef SORTER_DESC_EN
    chk("after_rst_const", 64'(got), 64'h03AF);
`else
    chk("after_rst_const", 64'(got), 64'hFA30);
`endif

    for (int r = 0; r < 30; r++) begin
      v = NN*W'($urandom);
      sort_one(v, int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
